// File: rtl/button_cmd_scheduler_pkg.sv
// Shared types and width helpers for the button command scheduler.
// The command record travels through the FIFO as a packed {id, is_repeat} pair.
package button_pkg;

  localparam int MAX_BTN  = 8;
  localparam int BTN_ID_W = $clog2(MAX_BTN);

  typedef struct packed {
    logic [BTN_ID_W-1:0] id;
    logic                is_repeat;
  } btn_cmd_t;

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/button_cmd_scheduler_if.sv
// Command handshake between the scheduler (master) and the control FSM (slave).
interface button_cmd_scheduler_if #(
  parameter int N_BTN = 4
);
  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic            cmd_valid;
  logic [ID_W-1:0] cmd_id;
  logic            cmd_repeat;
  logic            cmd_ready;

  modport master (output cmd_valid, cmd_id, cmd_repeat, input cmd_ready);
  modport slave  (input cmd_valid, cmd_id, cmd_repeat, output cmd_ready);
endinterface

// File: rtl/button_cmd_scheduler_fifo.sv
// Synchronous command FIFO; a push is accepted when full if a pop happens in the same cycle.
module btn_cmd_fifo
  import button_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  btn_cmd_t                push_data,
  input  logic                    pop,
  output btn_cmd_t                head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PTR_W = $clog2(DEPTH);

  btn_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is not reset; the head is masked while empty so stale entries never leak out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/button_cmd_scheduler.sv
// Round-robin scheduler turning button press/repeat events into an ordered command stream.
// Define BTN_AUTOREPEAT_EN to build the per-button hold counters and repeat events.
module button_cmd_scheduler
  import button_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_BTN-1:0]             btn_pulse,
  input  logic [N_BTN-1:0]             btn_level,
  button_cmd_scheduler_if.master       cmd,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  input  logic                         ovf_clr
);
  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] rep_flag;
  logic [N_BTN-1:0] pend_n;
  logic [N_BTN-1:0] flag_n;
  logic [N_BTN-1:0] rep_fire;
  logic [N_BTN-1:0] ev;
  logic [N_BTN-1:0] ev_rep;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_found;
  logic             gnt_any;
  logic             can_accept;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  btn_cmd_t         head;
  btn_cmd_t         push_data;
  logic             unused_ok;

  assign pop        = !fifo_empty && cmd.cmd_ready;
  assign can_accept = !fifo_full || pop;

  // A fresh press outranks a coincident repeat, so the flag only marks pure repeats.
  assign ev     = btn_pulse | rep_fire;
  assign ev_rep = rep_fire & ~btn_pulse;

  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = (int'(rr_ptr) + k) % N_BTN;
      if (!gnt_found && pending[ID_W'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
    gnt_any = gnt_found && can_accept;
  end

  always_comb begin
    pend_n = pending;
    flag_n = rep_flag;
    drop   = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (gnt_any && (gnt_idx == ID_W'(i))) begin
        pend_n[i] = ev[i];
        flag_n[i] = ev[i] && ev_rep[i];
      end else if (ev[i]) begin
        if (pending[i]) begin
          drop = 1'b1;
        end else begin
          pend_n[i] = 1'b1;
          flag_n[i] = ev_rep[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= '0;
      rep_flag <= '0;
      rr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pend_n;
      rep_flag <= flag_n;
      if (gnt_any) begin
        rr_ptr <= (int'(gnt_idx) == N_BTN-1) ? '0 : gnt_idx + 1'b1;
      end
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign push_data.id        = BTN_ID_W'(gnt_idx);
  assign push_data.is_repeat = rep_flag[gnt_idx];

  btn_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (gnt_any),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cmd.cmd_valid = !fifo_empty;
  assign cmd.cmd_id    = head.id[ID_W-1:0];

`ifdef BTN_AUTOREPEAT_EN
  localparam int HC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HC_W   = $clog2(HC_MAX + 1);
  localparam logic [HC_W-1:0] HOLD_TC = HC_W'(HOLD_CYCLES);
  localparam logic [HC_W-1:0] REP_TC  = HC_W'(REPEAT_CYCLES);

  for (genvar g = 0; g < N_BTN; g++) begin : g_hold
    logic [HC_W-1:0] hold_cnt;
    logic [HC_W-1:0] cnt_inc;
    logic            in_repeat;

    // cnt_inc is the number of high cycles including the current one.
    assign cnt_inc     = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
    assign rep_fire[g] = btn_level[g] && (cnt_inc == (in_repeat ? REP_TC : HOLD_TC));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold_cnt  <= '0;
        in_repeat <= 1'b0;
      end else if (!btn_level[g]) begin
        hold_cnt  <= '0;
        in_repeat <= 1'b0;
      end else if (rep_fire[g]) begin
        hold_cnt  <= '0;
        in_repeat <= 1'b1;
      end else begin
        hold_cnt  <= cnt_inc;
      end
    end
  end

  assign cmd.cmd_repeat = head.is_repeat;
  assign unused_ok      = ^head;
`else
  assign rep_fire       = '0;
  assign cmd.cmd_repeat = 1'b0;
  assign unused_ok      = ^{head, btn_level, 32'(HOLD_CYCLES), 32'(REPEAT_CYCLES)};
`endif

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_button_cmd_scheduler;
  localparam int N    = 8;
  localparam int D    = 4;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [N-1:0]         btn_pulse = '0;
  logic [N-1:0]         btn_level = '0;
  logic                 ovf_clr = 1'b0;
  logic [$clog2(D):0]   fifo_count;
  logic                 overflow;

  button_cmd_scheduler_if #(.N_BTN(N)) cif ();

  button_cmd_scheduler #(
    .N_BTN         (N),
    .FIFO_DEPTH    (D),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_pulse  (btn_pulse),
    .btn_level  (btn_level),
    .cmd        (cif),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: queue entries are id*2 + repeat flag; m_log records every consumed command.
  int m_q[$];
  int m_log[$];
  bit m_pend[N];
  bit m_flag[N];
  int m_hold[N];
  int m_rr;
  bit m_ovf;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_rr  = 0;
    m_ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_flag[i] = 1'b0;
      m_hold[i] = 0;
    end
  endfunction

  function automatic void model_step();
    bit ev[N];
    bit evr[N];
    bit rf;
    bit pop;
    bit can;
    bit drop;
    int g;
    drop = 1'b0;
    for (int i = 0; i < N; i++) begin
      rf = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      if (btn_level[i]) begin
        m_hold[i]++;
        rf = (m_hold[i] == HOLD) || (m_hold[i] > HOLD && ((m_hold[i] - HOLD) % REP) == 0);
      end else begin
        m_hold[i] = 0;
      end
`endif
      ev[i]  = btn_pulse[i] | rf;
      evr[i] = rf & ~btn_pulse[i];
    end
    pop = (m_q.size() > 0) && cif.cmd_ready;
    can = (m_q.size() < D) || pop;
    g = -1;
    if (can) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    if (pop) begin
      m_log.push_back(m_q[0]);
      void'(m_q.pop_front());
    end
    if (g >= 0) begin
      m_q.push_back(g * 2 + int'(m_flag[g]));
      m_rr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (i == g) begin
        m_pend[i] = ev[i];
        m_flag[i] = ev[i] & evr[i];
      end else if (ev[i]) begin
        if (m_pend[i]) drop = 1'b1;
        else begin
          m_pend[i] = 1'b1;
          m_flag[i] = evr[i];
        end
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  always @(negedge clk) begin
    if (rst) begin
      check("valid", 32'(cif.cmd_valid), 32'(m_q.size() > 0));
      check("count", 32'(fifo_count), 32'(m_q.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (m_q.size() > 0) begin
        check("id", 32'(cif.cmd_id), 32'(m_q[0] / 2));
        check("repeat", 32'(cif.cmd_repeat), 32'(m_q[0] % 2));
      end
    end
  end

  task automatic step(input logic [N-1:0] p);
    btn_pulse = p;
    @(negedge clk);
    #1;
    btn_pulse = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0);
  endtask

  function automatic int pend_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  initial begin
    int exp_drain[6] = '{2, 3, 4, 5, 6, 7};
    int presses;
    int repeats;
    int exp_reps;
    cif.cmd_ready = 1'b0;

    // Reset state
    #12;
    check("rst_valid", 32'(cif.cmd_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_id", 32'(cif.cmd_id), 0);
    check("rst_rep", 32'(cif.cmd_repeat), 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    // Single press: two-cycle latency, one-cycle valid with ready held high
    cif.cmd_ready = 1'b1;
    step(8'h04);
    check("single_t1_valid", 32'(cif.cmd_valid), 0);
    step('0);
    check("single_t2_valid", 32'(cif.cmd_valid), 1);
    check("single_t2_id", 32'(cif.cmd_id), 2);
    check("single_t2_rep", 32'(cif.cmd_repeat), 0);
    step('0);
    check("single_t3_valid", 32'(cif.cmd_valid), 0);

    // Press button 0 alone so the pointer lands on 1
    step(8'h01);
    idle(3);
    check("rr_model", 32'(m_rr), 1);

    // Simultaneous 0,1,3 with pointer at 1 -> 1,3,0
    cif.cmd_ready = 1'b0;
    step(8'b0000_1011);
    idle(3);
    check("simul_count", 32'(fifo_count), 3);
    check("simul_q_len", 32'(m_q.size()), 3);
    if (m_q.size() == 3) begin
      check("simul_q0", 32'(m_q[0]), 2);
      check("simul_q1", 32'(m_q[1]), 6);
      check("simul_q2", 32'(m_q[2]), 0);
    end
    m_log.delete();
    cif.cmd_ready = 1'b1;
    idle(5);
    check("simul_drained", 32'(m_log.size()), 3);

    // Backpressure: six presses, four queued, two pending
    cif.cmd_ready = 1'b0;
    step(8'b1111_1100);
    idle(5);
    check("bp_count", 32'(fifo_count), 4);
    check("bp_ovf", 32'(overflow), 0);
    check("bp_pending", 32'(pend_count()), 2);
    m_log.delete();
    cif.cmd_ready = 1'b1;
    idle(10);
    check("bp_drain_len", 32'(m_log.size()), 6);
    for (int i = 0; i < 6 && i < m_log.size(); i++) begin
      check("bp_drain_id", 32'(m_log[i] / 2), 32'(exp_drain[i]));
    end
    check("bp_empty", 32'(fifo_count), 0);

    // Drop: FIFO full, button 1 pulsed twice
    cif.cmd_ready = 1'b0;
    step(8'b1111_0000);
    idle(5);
    check("drop_full", 32'(fifo_count), 4);
    step(8'h02);
    step('0);
    check("drop_first_ok", 32'(overflow), 0);
    step(8'h02);
    check("drop_second_ovf", 32'(overflow), 1);
    idle(2);
    check("drop_sticky", 32'(overflow), 1);
    ovf_clr = 1'b1;
    step('0);
    ovf_clr = 1'b0;
    check("drop_cleared", 32'(overflow), 0);
    cif.cmd_ready = 1'b1;
    idle(8);

    // Auto-repeat: press and hold button 0 for 20 cycles
    m_log.delete();
    btn_level = 8'h01;
    step(8'h01);
    idle(19);
    btn_level = '0;
    idle(12);
    presses = 0;
    repeats = 0;
    foreach (m_log[i]) begin
      if (m_log[i] == 0) presses++;
      if (m_log[i] == 1) repeats++;
    end
`ifdef BTN_AUTOREPEAT_EN
    exp_reps = 4;
`else
    exp_reps = 0;
`endif
    check("hold_presses", 32'(presses), 1);
    check("hold_repeats", 32'(repeats), 32'(exp_reps));
    check("hold_total", 32'(m_log.size()), 32'(1 + exp_reps));

    // Reset mid-stream with three queued commands
    cif.cmd_ready = 1'b0;
    step(8'b0000_0111);
    idle(4);
    check("mid_queued", 32'(fifo_count), 3);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(cif.cmd_valid), 0);
    check("mid_rst_count", 32'(fifo_count), 0);
    check("mid_rst_id", 32'(cif.cmd_id), 0);
    check("mid_rst_rep", 32'(cif.cmd_repeat), 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    cif.cmd_ready = 1'b1;
    idle(5);
    check("mid_no_stale", 32'(cif.cmd_valid), 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] p;
      p = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) p[i] = 1'b1;
        if ($urandom_range(0, 15) == 0) btn_level[i] = ~btn_level[i];
      end
      cif.cmd_ready = (c % 500 < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      ovf_clr = ($urandom_range(0, 19) == 0);
      step(p);
    end
    ovf_clr = 1'b0;
    btn_level = '0;
    cif.cmd_ready = 1'b1;
    idle(30);
    check("final_empty", 32'(fifo_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/button_cmd_scheduler.md
# button_cmd_scheduler

Collects the one-cycle edge pulses produced by the board's `pushbutton` instances and turns them into an ordered stream of button commands for the control FSM. Simultaneous presses are shared fairly by a round-robin arbiter and buffered in a small FIFO. Presses are never silently lost: a press that cannot be recorded sets a sticky overflow flag. An optional auto-repeat engine emits repeat commands while a button is held.

## Interface
- `N_BTN`, 4: number of buttons (2..8).
- `FIFO_DEPTH`, 4: command FIFO entries (power of 2, ≥2).
- `HOLD_CYCLES`, 50_000_000: level-high cycles before first repeat (≥2).
- `REPEAT_CYCLES`, 10_000_000: cycles between subsequent repeats (≥2).

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `btn_pulse`  in  N_BTN  one-cycle press pulses from `pushbutton` outputs.
- `btn_level`  in  N_BTN  debounced button levels, used for hold detection.
- `cmd_valid`  out  1  FIFO head valid.
- `cmd_id`  out  $clog2(N_BTN)  button index at head.
- `cmd_repeat`  out  1  head is an auto-repeat event (0 = fresh press).
- `cmd_ready`  in  1  consumer accepts head.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- `overflow`  out  1  sticky; an event was dropped.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- Reset (`rst`=0): pending bits, repeat flags, RR pointer, FIFO, and hold counters are cleared; `cmd_valid`=0, `cmd_id`=0, `cmd_repeat`=0, `fifo_count`=0, `overflow`=0.
- Each button has a pending bit plus a repeat flag. An event (pulse or repeat) for button i sets pending[i] on the next edge and records whether it was a repeat.
- Arbiter: every cycle, the first pending bit at or after `rr_ptr` (wrapping) is granted if the FIFO can accept. A grant writes {i, flag} to the FIFO and clears pending[i]. `rr_ptr` then moves to (i+1) mod N_BTN.
- FIFO can accept when not full, or when full and popped in the same cycle.
- Pop on `cmd_valid && cmd_ready`. `cmd_id`/`cmd_repeat` must be stable while `cmd_valid && !cmd_ready`.
- A new event for i when pending[i]=1 and i is not granted that cycle: the event is dropped and `overflow`←1.
- A new event for i in the same cycle i is granted: pending[i] stays 1 with the new flag. There is no drop.
- FIFO full with no pop: pending bits hold. Drops occur only as described above.
- `overflow` set and `ovf_clr` in the same cycle: set wins.

## Timing
- Pulse in cycle t with an idle, empty FIFO: pending set at edge t+1; FIFO write at edge t+2; `cmd_valid`=1 in cycle t+2 (2-cycle latency).
- Maximum throughput is one grant and one pop per cycle.
- Hold counter i is cleared while `btn_level[i]`=0, and counts while it is 1.
    - The first repeat event fires in the cycle where the count reaches HOLD_CYCLES.
    - The counter then reloads, and further events fire every REPEAT_CYCLES.
    - A counter saturates rather than wraps when no repeat applies.
- Releasing a button stops future repeats. Events already pending or queued remain.
- Asynchronous reset mid-operation discards all queued and pending commands.

## Configuration
- `BTN_AUTOREPEAT_EN` defined: hold counters and repeat events exist; `cmd_repeat` may be 1.
- Undefined: no counters are synthesized; `btn_level` is ignored; `cmd_repeat` is tied to 0; `HOLD_CYCLES`/`REPEAT_CYCLES` are unused.

## Structure
- Package `button_pkg` holds:
    - max button count constant;
    - `btn_cmd_t` typedef {id, repeat};
    - width helper constants for id and count.
- Sub-module `btn_cmd_fifo`: synchronous FIFO of `btn_cmd_t`, FIFO_DEPTH deep. It has full/empty/count outputs and supports simultaneous push/pop when full.
- Arbiter, pending logic, and hold counters stay in the top module.

## Test plan
- Single press: pulse btn 2 at t, `cmd_ready`=1 → `cmd_valid`=1 at t+2 with `cmd_id`=2, `cmd_repeat`=0, for one cycle.
- Simultaneous: pulses on btns 0,1,3 in one cycle with `rr_ptr`=1 → FIFO order 1,3,0 on consecutive cycles; `fifo_count` reaches 3.
- Backpressure: `cmd_ready`=0, 6 presses on distinct buttons with FIFO_DEPTH=4 → `fifo_count`=4, 2 pending, `overflow`=0. Then `cmd_ready`=1 → all 6 drain in arbitration order.
- Drop: `cmd_ready`=0, FIFO full, btn 1 pulsed twice → `overflow`=1 after the second pulse. `ovf_clr` → 0.
- Auto-repeat (`BTN_AUTOREPEAT_EN`, HOLD=8, REPEAT=4): btn 0 pulsed then held 20 cycles → one press command, then repeat commands at hold counts 8, 12, 16, 20. Release stops them.
- Reset mid-stream: `rst`=0 with 3 queued → all outputs 0 immediately. After release, no stale commands.
